// File: rtl/memory_unit.sv
// memory_unit: single-port word store with a free-address allocator.
// A scan after reset finds the first all-zero word and uses it as the
// starting free pointer; commands are then accepted on execute rising edges.

`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 10
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 68
`endif

module memory_unit_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 68
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] ram [0:DEPTH-1];

  // Synchronous write and registered read-before-write, one cycle latency
  always_ff @(posedge clk) begin
    if (we) ram[addr] <= wdata;
    rdata <= ram[addr];
  end
endmodule

module memory_unit #(
  parameter int ADDR_W = `MEMORY_ADDR_WIDTH,
  parameter int DATA_W = `MEMORY_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power,
  input  logic [1:0]        func,
  input  logic              execute,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              is_ready,
  output logic [3:0]        state,
  output logic [DATA_W-1:0] mem_data_out
);
  localparam logic [1:0] GET_CONTENTS = 2'd0;
  localparam logic [1:0] SET_CONTENTS = 2'd1;
  localparam logic [1:0] GET_FREE     = 2'd2;

  localparam logic [ADDR_W-1:0] ALL_ONES = '1;
  localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_INIT      = 4'h0,
    S_IDLE      = 4'h1,
    S_READ      = 4'h2,
    S_READ_DONE = 4'h3,
    S_WRITE     = 4'h4,
    S_FREE      = 4'h5,
    S_DONE      = 4'h6
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              exec_prev;
  logic              accept;
  logic [ADDR_W-1:0] free_ptr;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_chk;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign accept       = (state_q == S_IDLE) && power && execute && !exec_prev;
  assign is_ready     = (state_q == S_IDLE) && power;
  assign state        = state_q;
  assign mem_data_out = ram_rdata;
  assign ram_addr     = (state_q == S_INIT) ? scan_addr : lat_addr;
  assign ram_we       = (state_q == S_WRITE);

  memory_unit_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (lat_data),
    .rdata (ram_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_INIT;
    else      state_q <= state_d;
  end

  // Next-state decode; the scan ends on the first zero word or the last address
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:      if (scan_chk && ((ram_rdata == '0) || (scan_addr == ALL_ONES)))
                     state_d = S_IDLE;
      S_IDLE:      if (accept) begin
                     case (func)
                       GET_CONTENTS: state_d = S_READ;
                       SET_CONTENTS: state_d = S_WRITE;
                       GET_FREE:     state_d = S_FREE;
                       default:      state_d = S_DONE;
                     endcase
                   end
      S_READ:      state_d = S_READ_DONE;
      S_READ_DONE: state_d = S_IDLE;
      S_WRITE:     state_d = S_DONE;
      S_FREE:      state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_INIT;
    endcase
  end

  // Control: edge history, init scan (issue/check per address), allocator, read capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exec_prev <= 1'b1;
      addr_out  <= '0;
      data_out  <= '0;
      free_ptr  <= '0;
      scan_addr <= '0;
      scan_chk  <= 1'b0;
    end else begin
      exec_prev <= execute;
      if (state_q == S_INIT) begin
        if (!scan_chk) begin
          scan_chk <= 1'b1;
        end else begin
          scan_chk <= 1'b0;
          if (ram_rdata == '0)           free_ptr  <= scan_addr;
          else if (scan_addr == ALL_ONES) free_ptr <= ALL_ONES;
          else                            scan_addr <= scan_addr + ONE;
        end
      end
      if (accept && (func == GET_FREE)) begin
        addr_out <= free_ptr;
        if (free_ptr != ALL_ONES) free_ptr <= free_ptr + ONE;
      end
      if (state_q == S_READ_DONE) data_out <= ram_rdata;
    end
  end

  // Command operand capture, only meaningful after an accepted command
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr <= addr_in;
      lat_data <= data_in;
    end
  end
endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: directed vectors for memory_unit plus hand-written
// sequences for held execute, power gating and reset during a write.

module tb_memory_unit;
  localparam int AW = 10;
  localparam int DW = 68;

  localparam logic [DW-1:0] P0 = 68'hA_0000_0000_0000_0011;
  localparam logic [DW-1:0] P1 = 68'h22;
  localparam logic [DW-1:0] P2 = 68'h3_3333;
  localparam logic [DW-1:0] P3 = 68'hF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] DB = 68'hDEADBEEF;
  localparam logic [DW-1:0] X6 = 68'h1_2345_6789_ABCD_EF01;

  logic          clk = 1'b0;
  logic          rst;
  logic          power;
  logic [1:0]    func;
  logic          execute;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic          is_ready;
  logic [3:0]    state;
  logic [DW-1:0] mem_data_out;

  int n_cmp  = 0;
  int n_miss = 0;

  typedef struct {
    logic [1:0]    f;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          chk_addr;
    logic [AW-1:0] exp_addr;
    logic          chk_data;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs [0:10];

  memory_unit dut (
    .clk          (clk),
    .rst          (rst),
    .power        (power),
    .func         (func),
    .execute      (execute),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .addr_out     (addr_out),
    .data_out     (data_out),
    .is_ready     (is_ready),
    .state        (state),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name, input int limit, output int cyc);
    cyc = 0;
    while (!is_ready && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(name, DW'(is_ready), DW'(1));
  endtask

  task automatic do_cmd(input int idx, input vec_t v);
    int cyc;
    logic [DW-1:0] md;
    logic rd_seen;
    @(negedge clk);
    func = v.f; addr_in = v.a; data_in = v.d; execute = 1'b1;
    @(posedge clk); #1;
    check($sformatf("v%0d_accept_ready", idx), DW'(is_ready), DW'(0));
    @(negedge clk);
    execute = 1'b0;
    cyc = 1; rd_seen = 1'b0; md = '0;
    while (!is_ready && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      if (state == 4'h3) begin
        md = mem_data_out;
        rd_seen = 1'b1;
      end
    end
    check($sformatf("v%0d_latency", idx), DW'(is_ready && cyc <= 4), DW'(1));
    if (v.chk_addr) check($sformatf("v%0d_addr_out", idx), DW'(addr_out), DW'(v.exp_addr));
    if (v.chk_data) check($sformatf("v%0d_data_out", idx), data_out, v.exp_data);
    if (v.f == 2'd0) begin
      check($sformatf("v%0d_read_state_seen", idx), DW'(rd_seen), DW'(1));
      check($sformatf("v%0d_mem_data_out", idx), md, v.exp_data);
    end
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{2'd2, 10'd0, '0, 1'b1, 10'd5, 1'b0, '0};
    vecs[1]  = '{2'd1, 10'd4, DB, 1'b1, 10'd5, 1'b0, '0};
    vecs[2]  = '{2'd0, 10'd0, '0, 1'b1, 10'd5, 1'b1, P0};
    vecs[3]  = '{2'd0, 10'd1, '0, 1'b1, 10'd5, 1'b1, P1};
    vecs[4]  = '{2'd0, 10'd2, '0, 1'b1, 10'd5, 1'b1, P2};
    vecs[5]  = '{2'd0, 10'd3, '0, 1'b1, 10'd5, 1'b1, P3};
    vecs[6]  = '{2'd0, 10'd4, '0, 1'b1, 10'd5, 1'b1, DB};
    vecs[7]  = '{2'd3, 10'd9, X6, 1'b1, 10'd5, 1'b1, DB};
    vecs[8]  = '{2'd1, 10'd6, X6, 1'b1, 10'd5, 1'b1, DB};
    vecs[9]  = '{2'd0, 10'd6, '0, 1'b1, 10'd5, 1'b1, X6};
    vecs[10] = '{2'd2, 10'd0, '0, 1'b1, 10'd6, 1'b1, X6};

    rst = 1'b0; power = 1'b1; func = 2'd0; execute = 1'b0;
    addr_in = '0; data_in = '0;
    #1;
    for (int i = 0; i < (1 << AW); i++) dut.ram.ram[i] = '0;
    dut.ram.ram[0] = P0;
    dut.ram.ram[1] = P1;
    dut.ram.ram[2] = P2;
    dut.ram.ram[3] = P3;

    // Reset state
    @(posedge clk); #1;
    check("rst_state", DW'(state), DW'(4'h0));
    check("rst_ready", DW'(is_ready), DW'(0));
    check("rst_addr_out", DW'(addr_out), DW'(0));
    check("rst_data_out", data_out, '0);

    @(negedge clk); rst = 1'b1;
    wait_ready("init_done", 2 * (1 << AW) + 2, cyc);
    check("init_state_idle", DW'(state), DW'(4'h1));

    // GET_FREE with execute held for two edges
    @(negedge clk); func = 2'd2; execute = 1'b1;
    @(posedge clk); #1;
    check("held_state_free", DW'(state), DW'(4'h5));
    check("held_ready_low", DW'(is_ready), DW'(0));
    @(posedge clk); #1;
    check("held_addr_out", DW'(addr_out), DW'(4));
    wait_ready("held_ready_back", 4, cyc);
    @(posedge clk); #1;
    check("held_no_retrigger", DW'(state), DW'(4'h1));
    @(negedge clk); execute = 1'b0;

    for (int i = 0; i <= 10; i++) do_cmd(i, vecs[i]);

    // Power gating: pulse ignored, allocator untouched
    @(negedge clk); power = 1'b0; func = 2'd2;
    @(posedge clk); #1;
    check("pwr_ready_low", DW'(is_ready), DW'(0));
    @(negedge clk); execute = 1'b1;
    @(negedge clk); execute = 1'b0;
    @(posedge clk); #1;
    check("pwr_state_idle", DW'(state), DW'(4'h1));
    check("pwr_addr_out", DW'(addr_out), DW'(6));
    @(negedge clk); power = 1'b1;
    @(posedge clk); #1;
    check("pwr_ready_back", DW'(is_ready), DW'(1));
    do_cmd(11, '{2'd2, 10'd0, '0, 1'b1, 10'd7, 1'b0, '0});

    // Reset during WRITE discards the write and reruns the scan
    @(negedge clk); func = 2'd1; addr_in = 10'd0; data_in = 68'h5555; execute = 1'b1;
    @(posedge clk); #1;
    check("rw_state_write", DW'(state), DW'(4'h4));
    #2 rst = 1'b0;
    #1;
    check("rw_async_init", DW'(state), DW'(4'h0));
    check("rw_async_addr_out", DW'(addr_out), DW'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    wait_ready("rw_init_done", 2 * (1 << AW) + 2, cyc);
    repeat (2) @(posedge clk);
    #1;
    check("rw_exec_high_ignored", DW'(state), DW'(4'h1));
    @(negedge clk); execute = 1'b0;
    do_cmd(12, '{2'd2, 10'd0, '0, 1'b1, 10'd5, 1'b0, '0});
    do_cmd(13, '{2'd0, 10'd0, '0, 1'b1, 10'd5, 1'b1, P0});

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end
endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 Parameters (memory_unit.vh macros): memory_addr_width, default 10, address width AW; memory_data_width, default 68, word width DW.
REQ-002 Function codes (memory_unit.vh): GET_CONTENTS=2'd0 read word; SET_CONTENTS=2'd1 write word; GET_FREE=2'd2 allocate next free address; 2'd3 reserved, no-op.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 power  input  1  enable; 0 blocks command acceptance.
REQ-006 func  input  2  operation code.
REQ-007 execute  input  1  command request.
REQ-008 addr_in  input  AW  target address for GET/SET_CONTENTS.
REQ-009 data_in  input  DW  write data for SET_CONTENTS.
REQ-010 addr_out  output  AW  address returned by GET_FREE.
REQ-011 data_out  output  DW  word returned by GET_CONTENTS.
REQ-012 is_ready  output  1  1 = idle, command can be accepted.
REQ-013 state  output  4  current FSM state encoding.
REQ-014 mem_data_out  output  DW  raw RAM read-port output, unregistered by the FSM.

Function
REQ-015 Storage: internal synchronous single-port RAM, instance name ram, array name ram, depth 2^AW x DW, 1-cycle read latency; contents not altered by reset, preloadable by hierarchical $readmemh.
REQ-016 States/encoding: INIT=4'h0, IDLE=4'h1, READ=4'h2, READ_DONE=4'h3, WRITE=4'h4, FREE=4'h5, DONE=4'h6.
REQ-017 INIT: scan addresses from 0 upward; free pointer := first address whose word == 0; if none, free pointer := all-ones; then IDLE. Max INIT latency 2*2^AW+2 cycles.
REQ-018 Acceptance: in IDLE with power=1, a command is accepted on the first rising edge where execute=1 and execute was 0 on the previous edge (rising-edge detect); a held-high execute never re-triggers.
REQ-019 is_ready=1 only in IDLE with power=1; drops to 0 on the acceptance edge and stays 0 until return to IDLE.
REQ-020 GET_FREE: on acceptance edge addr_out <= free pointer, free pointer <= free pointer+1 (saturates at all-ones; no wrap); FREE -> DONE -> IDLE.
REQ-021 SET_CONTENTS: addr_in/data_in latched on acceptance edge; RAM written in WRITE; WRITE -> DONE -> IDLE. Writing a nonzero word does not move the free pointer.
REQ-022 GET_CONTENTS: addr_in latched on acceptance edge; READ issues RAM read; READ_DONE captures RAM output into data_out; -> IDLE. data_out valid when is_ready returns to 1 and held until the next completed read.
REQ-023 Every accepted command returns is_ready=1 within 4 cycles of acceptance.
REQ-024 func=3 accepted then returns to IDLE via DONE with no side effects.
REQ-025 Inputs other than execute/power ignored outside IDLE; power dropping mid-operation does not abort it.

Reset
REQ-026 rst=0 asynchronously forces: state=INIT, is_ready=0, addr_out=0, data_out=0, free pointer=0, execute-edge history=1 (a high execute at reset release is not a command).
REQ-027 Reset asserted mid-operation aborts it; a pending write not yet performed is discarded; INIT scan reruns after release.

Verification
REQ-028 Preload words 0..3 nonzero, word 4 = 0; release reset -> is_ready=1 after INIT, state=4'h1.
REQ-029 GET_FREE, execute held 2 cycles -> addr_out=4 by 2nd edge, is_ready returns 1; second GET_FREE -> addr_out=5.
REQ-030 SET_CONTENTS addr 4, data 68'hDEADBEEF -> subsequent GET_CONTENTS addr 4 returns data_out=68'hDEADBEEF.
REQ-031 GET_CONTENTS sweep addr 0..4 -> data_out equals preload words, then DEADBEEF; mem_data_out matches RAM one cycle after each read.
REQ-032 power=0 with execute pulse -> is_ready=0, no command; reset pulse during WRITE -> target word unchanged, INIT reruns.
